fifo_hs_reader: RTL and testbench

Read-side front end for the FIFO_HS dual-clock command FIFO. Lives entirely in the read clock domain. Drains FIFO_HS through its non-show-ahead port (RdEn, Q, Empty) and hides the one-cycle read latency behind a 2-entry local buffer. Presents entries downstream as a valid/ready stream at one entry per cycle sustained. Also keeps a running count of delivered entries.

---
 rtl/fifo_hs_reader_if.sv | 25 ++
 rtl/fifo_hs_reader.sv | 82 ++++++++
 tb/tb_fifo_hs_reader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_hs_reader_if.sv
// Handshake bundle for the FIFO_HS read front end.
// master: the reader (drives RdEn and the downstream stream).
// slave:  the environment (FIFO_HS read port plus the downstream sink).
interface fifo_hs_reader_if #(
    parameter int WIDTH = 179
);
    // FIFO_HS non-show-ahead read port
    logic             Empty;
    logic [WIDTH-1:0] Q;
    logic             RdEn;
    // downstream valid/ready stream
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        input  Empty, Q, m_ready,
        output RdEn, m_valid, m_data
    );

    modport slave (
        output Empty, Q, m_ready,
        input  RdEn, m_valid, m_data
    );
endinterface

// File: rtl/fifo_hs_reader.sv
// Read-side front end for FIFO_HS. Hides the one-cycle Q latency behind a
// two-entry buffer (out_reg + skid_reg) so the downstream stream can run at
// one entry per cycle, and counts delivered entries.
module fifo_hs_reader #(
    parameter int WIDTH = 179,
    parameter int CNT_W = 16
) (
    input  logic             RdClk,
    input  logic             Reset,
    fifo_hs_reader_if.master bus,
    output logic [1:0]       level,
    output logic [CNT_W-1:0] pop_cnt
);
    // Occupancy states; the encoding is the occupancy itself.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] skid_reg;
    logic             rd_pend;   // Q is arriving this cycle
    logic             pop;
    logic             rd_en;
    logic [2:0]       credit;

    assign bus.m_valid = (level != S_EMPTY);
    assign bus.m_data  = out_reg;
    assign bus.RdEn    = rd_en;

    // Slots already committed after this cycle: held + in flight - leaving.
    // pop implies level >= 1, so the subtraction cannot go negative.
    always_comb begin
        pop    = bus.m_valid && bus.m_ready;
        credit = {1'b0, level} + {2'b00, rd_pend} - {2'b00, pop};
        rd_en  = !Reset && !bus.Empty && (credit < 3'd2);
    end

    // Occupancy FSM, data shifting, in-flight tracking and pop counting.
    always_ff @(posedge RdClk) begin
        if (Reset) begin
            level    <= S_EMPTY;
            rd_pend  <= 1'b0;
            out_reg  <= '0;
            skid_reg <= '0;
            pop_cnt  <= '0;
        end else begin
            rd_pend <= rd_en;
            if (pop)
                pop_cnt <= pop_cnt + CNT_W'(1);
            case (level)
                S_EMPTY: begin
                    if (rd_pend) begin
                        out_reg <= bus.Q;
                        level   <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (rd_pend && !pop) begin
                        skid_reg <= bus.Q;
                        level    <= S_TWO;
                    end else if (rd_pend && pop) begin
                        out_reg <= bus.Q;
                    end else if (pop) begin
                        level <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    // credit keeps rd_pend low on entry to TWO, but a capture
                    // alongside a pop is still handled for safety.
                    if (pop) begin
                        out_reg <= skid_reg;
                        if (rd_pend)
                            skid_reg <= bus.Q;
                        else
                            level <= S_ONE;
                    end
                end
                default: level <= S_EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_hs_reader.sv
// Directed bench for fifo_hs_reader with a behavioural FIFO_HS read port
// and a scoreboard of expected entries in delivery order.
module tb_fifo_hs_reader;
    localparam int W  = 179;
    localparam int CW = 4;

    logic          RdClk = 1'b0;
    logic          Reset = 1'b1;
    logic [1:0]    level;
    logic [CW-1:0] pop_cnt;

    fifo_hs_reader_if #(.WIDTH(W)) bus ();

    fifo_hs_reader #(.WIDTH(W), .CNT_W(CW)) dut (
        .RdClk   (RdClk),
        .Reset   (Reset),
        .bus     (bus),
        .level   (level),
        .pop_cnt (pop_cnt)
    );

    always #5 RdClk = ~RdClk;

    // FIFO_HS model: storage written by the stimulus, read pointer owned here.
    logic [W-1:0] mem [256];
    logic [7:0]   wr_cnt = 8'd0;
    logic [7:0]   rd_cnt = 8'd0;
    logic [W-1:0] q_reg  = '0;

    assign bus.Empty = (wr_cnt == rd_cnt);
    assign bus.Q     = q_reg;

    // Non-show-ahead read: Q appears the cycle after RdEn; reset empties it.
    always @(posedge RdClk) begin
        if (Reset)
            rd_cnt <= wr_cnt;
        else if (bus.RdEn) begin
            q_reg  <= mem[rd_cnt];
            rd_cnt <= rd_cnt + 8'd1;
        end
    end

    logic [W-1:0] exp_q [$];
    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge RdClk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] d, input bit track);
        mem[wr_cnt] = d;
        wr_cnt      = wr_cnt + 8'd1;
        if (track)
            exp_q.push_back(d);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        exp_q.delete();
        tick();
        Reset = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] v = '0;
        for (int k = 0; k < 6; k++)
            v = {v[W-33:0], 32'($urandom)};
        return v;
    endfunction

    // Delivery monitor: scoreboard, hold stability, no read while empty.
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;
    always @(negedge RdClk) begin
        if (armed && !Reset) begin
            chk("rden_while_empty", W'(bus.RdEn && bus.Empty), W'(0));
            if (prev_hold) begin
                chk("hold_valid", W'(bus.m_valid), W'(1));
                chk("hold_data", bus.m_data, prev_data);
            end
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                if (exp_q.size() == 0)
                    chk("sb_extra", bus.m_data, 'x);
                else
                    chk("sb_data", bus.m_data, exp_q.pop_front());
            end
        end
        prev_hold = armed && !Reset && (bus.m_valid === 1'b1) && (bus.m_ready === 1'b0);
        prev_data = bus.m_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd_pulses;
        bus.m_ready = 1'b0;

        // Reset held with FIFO non-empty
        tick();
        armed = 1'b1;
        for (int c = 0; c < 3; c++) begin
            load(W'(32'hdead0000 + c), 1'b0);
            #1;
            chk("rst_rden", W'(bus.RdEn), W'(0));
            chk("rst_valid", W'(bus.m_valid), W'(0));
            chk("rst_level", W'(level), W'(0));
            chk("rst_popcnt", W'(pop_cnt), W'(0));
            chk("rst_data", bus.m_data, W'(0));
            tick();
        end
        Reset = 1'b0;

        // Single entry
        bus.m_ready = 1'b1;
        load(W'(1), 1'b1);
        #1;
        chk("one_rden_c0", W'(bus.RdEn), W'(1));
        tick(); #1;
        chk("one_rden_c1", W'(bus.RdEn), W'(0));
        chk("one_valid_c1", W'(bus.m_valid), W'(0));
        tick(); #1;
        chk("one_valid_c2", W'(bus.m_valid), W'(1));
        chk("one_data_c2", bus.m_data, W'(1));
        tick(); #1;
        chk("one_valid_c3", W'(bus.m_valid), W'(0));
        chk("one_popcnt", W'(pop_cnt), W'(1));

        // Streaming 0..7
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) load(W'(i), 1'b1);
        rd_pulses = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.RdEn === 1'b1) rd_pulses++;
            if (c >= 2 && c <= 9) begin
                chk("str_valid", W'(bus.m_valid), W'(1));
                chk("str_data", bus.m_data, W'(c - 2));
            end else
                chk("str_idle", W'(bus.m_valid), W'(0));
            tick();
        end
        chk("str_rden_pulses", W'(rd_pulses), W'(8));
        chk("str_popcnt", W'(pop_cnt), W'(8));

        // Backpressure: ready low cycles 4..9
        do_reset();
        for (int i = 0; i < 12; i++) load(W'(16'h100 + i), 1'b1);
        for (int c = 0; c < 22; c++) begin
            bus.m_ready = (c < 4 || c >= 10);
            #1;
            if (c >= 5 && c <= 9) begin
                chk("bp_level", W'(level), W'(2));
                chk("bp_rden", W'(bus.RdEn), W'(0));
                chk("bp_data", bus.m_data, W'(16'h102));
            end
            if (c >= 2 && c <= 19)
                chk("bp_gapfree", W'(bus.m_valid), W'(1));
            tick();
        end
        chk("bp_popcnt", W'(pop_cnt), W'(12));
        chk("bp_drained", W'(exp_q.size()), W'(0));

        // Reset mid-stream while Q is in flight
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) load(W'(16'h200 + i), 1'b1);
        for (int c = 0; c < 4; c++) tick();
        Reset = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rden", W'(bus.RdEn), W'(0));
        tick();
        Reset = 1'b0;
        #1;
        chk("mid_valid", W'(bus.m_valid), W'(0));
        chk("mid_level", W'(level), W'(0));
        chk("mid_popcnt", W'(pop_cnt), W'(0));
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            chk("mid_stale", W'(bus.m_valid), W'(0));
        end
        for (int i = 0; i < 3; i++) load(W'(16'ha0 + i), 1'b1);
        for (int c = 0; c < 6; c++) tick();
        chk("mid_restart_popcnt", W'(pop_cnt), W'(3));
        chk("mid_restart_drained", W'(exp_q.size()), W'(0));

        // Counter wrap with random ready
        do_reset();
        for (int i = 0; i < 17; i++) load(rnd_word(), 1'b1);
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        tick();
        chk("wrap_drained", W'(exp_q.size()), W'(0));
        chk("wrap_popcnt", W'(pop_cnt), W'(1));
        chk("wrap_idle", W'(bus.m_valid), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
